// File: rtl/comparator_4bit_if.sv
// Operand/cascade request bundle and registered compare result for comparator_4bit.
// The master drives operands and cascade inputs. The slave, which is the comparator, returns the flags.
interface comparator_4bit_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             signed_mode;
  logic             casc_lt;
  logic             casc_gt;
  logic             casc_eq;
  logic             out_valid;
  logic             A_lt_B;
  logic             A_gt_B;
  logic             A_eq_B;

  modport master (
    output in_valid, A, B, signed_mode, casc_lt, casc_gt, casc_eq,
    input  out_valid, A_lt_B, A_gt_B, A_eq_B
  );

  modport slave (
    input  in_valid, A, B, signed_mode, casc_lt, casc_gt, casc_eq,
    output out_valid, A_lt_B, A_gt_B, A_eq_B
  );
endinterface

// File: rtl/comparator_4bit.sv
// Registered WIDTH-bit magnitude comparator with signed/unsigned mode and cascade inputs.
// The result is one-hot and is available one cycle after an accepted input.
module comparator_4bit #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  comparator_4bit_if.slave   bus
);

  // MSB-first scan: the first differing bit decides; in signed mode a set sign bit means smaller
  function automatic logic [1:0] scan_cmp(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             sm
  );
    logic lt;
    logic gt;
    lt = 1'b0;
    gt = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!lt && !gt && (a[i] != b[i])) begin
        if (sm && (i == WIDTH - 1)) begin
          lt = a[i];
          gt = b[i];
        end else begin
          lt = b[i];
          gt = a[i];
        end
      end else begin
        lt = lt;
        gt = gt;
      end
    end
    return {lt, gt};
  endfunction

  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic [1:0]       local_s;
  logic             lt_s;
  logic             gt_s;
  logic             eq_s;
  logic             out_valid_r;
  logic             lt_r;
  logic             gt_r;
  logic             eq_r;

  assign a_s     = bus.A;
  assign b_s     = bus.B;
  assign local_s = scan_cmp(a_s, b_s, bus.signed_mode);

  // Local result wins on inequality; on a tie the cascade chain decides (eq > gt > lt)
  always_comb begin
    lt_s = 1'b0;
    gt_s = 1'b0;
    eq_s = 1'b0;
    if (local_s != 2'b00) begin
      lt_s = local_s[1];
      gt_s = local_s[0];
    end else if (bus.casc_eq) begin
      eq_s = 1'b1;
    end else if (bus.casc_gt) begin
      gt_s = 1'b1;
    end else if (bus.casc_lt) begin
      lt_s = 1'b1;
    end else begin
      eq_s = 1'b1;
    end
  end

  // Result register: capture on accept; otherwise drop valid and hold the flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      lt_r        <= 1'b0;
      gt_r        <= 1'b0;
      eq_r        <= 1'b0;
    end else if (bus.in_valid) begin
      out_valid_r <= 1'b1;
      lt_r        <= lt_s;
      gt_r        <= gt_s;
      eq_r        <= eq_s;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.A_lt_B    = lt_r;
  assign bus.A_gt_B    = gt_r;
  assign bus.A_eq_B    = eq_r;

endmodule

// File: tb/tb_comparator_4bit.sv
// Scoreboard bench for comparator_4bit: the driver queues reference results, and the monitor pops them on out_valid.
module tb_comparator_4bit;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [2:0] exp_q[$];
  logic [2:0] last_exp = 3'b000;
  logic [2:0] pend     = 3'b000;

  comparator_4bit_if #(.WIDTH(4)) bus_if ();

  comparator_4bit #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: compare as integers, then resolve ties through the cascade. The result is {lt,gt,eq}.
  function automatic logic [2:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic sm, input logic cl,
                                       input logic cg, input logic ce);
    int av;
    int bv;
    av = int'(a);
    bv = int'(b);
    if (sm && av >= 8) av = av - 16;
    if (sm && bv >= 8) bv = bv - 16;
    if (av < bv) return 3'b100;
    if (av > bv) return 3'b010;
    if (ce) return 3'b001;
    if (cg) return 3'b010;
    if (cl) return 3'b100;
    return 3'b001;
  endfunction

  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic sm,
                       input logic cl, input logic cg, input logic ce);
    bus_if.in_valid    = 1'b1;
    bus_if.A           = a;
    bus_if.B           = b;
    bus_if.signed_mode = sm;
    bus_if.casc_lt     = cl;
    bus_if.casc_gt     = cg;
    bus_if.casc_eq     = ce;
    pend               = model(a, b, sm, cl, cg, ce);
  endtask

  task automatic accept();
    @(posedge clk);
    if (rst_n) exp_q.push_back(pend);
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic sm,
                      input logic cl, input logic cg, input logic ce);
    @(negedge clk);
    apply(a, b, sm, cl, cg, ce);
    accept();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic send_rand();
    send(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, int'(bus_if.out_valid), 0);
    check({tag, "_flags"}, int'({bus_if.A_lt_B, bus_if.A_gt_B, bus_if.A_eq_B}), 0);
  endtask

  // A reset discards any result still in flight.
  always @(negedge rst_n) begin
    exp_q.delete();
    last_exp = 3'b000;
  end

  // Monitor: pop on each out_valid; when idle, the flags must hold the last result.
  always @(negedge clk) begin
    logic [2:0] got;
    logic [2:0] e;
    got = {bus_if.A_lt_B, bus_if.A_gt_B, bus_if.A_eq_B};
    if (bus_if.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("flags", int'(got), int'(e));
        check("onehot", int'($countones(got)), 1);
        last_exp = e;
      end
    end else begin
      check("held_flags", int'(got), int'(last_exp));
    end
  end

  initial begin
    bus_if.in_valid = 1'b0;
    bus_if.A = 4'd0; bus_if.B = 4'd0; bus_if.signed_mode = 1'b0;
    bus_if.casc_lt = 1'b0; bus_if.casc_gt = 1'b0; bus_if.casc_eq = 1'b1;

    // Reset held with live traffic: nothing may come out
    repeat (3) send_rand();
    #1 check_zero("reset");
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    rst_n = 1'b1;

    send(4'd2, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    send(4'd8, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    send(4'd12, 4'd12, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    send(4'b1000, 4'b0111, 1'b1, 1'b0, 1'b0, 1'b1);
    send(4'b1000, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b1);
    send(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
    send(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1);
    send(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);

    send(4'd9, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0);
    send(4'd9, 4'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    send(4'd9, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    send(4'd9, 4'd9, 1'b0, 1'b1, 1'b1, 1'b1);
    send(4'd3, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);

    for (int sm = 0; sm < 2; sm++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          send(4'(a), 4'(b), 1'(sm), 1'b0, 1'b0, 1'b1);
    idle(1);

    for (int n = 0; n < 300; n++) begin
      send_rand();
      if ($urandom_range(3) == 0) idle(int'($urandom_range(2)) + 1);
    end

    // Reset asserted between edges while results are still in flight
    repeat (3) send_rand();
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    @(posedge clk);
    #1 check_zero("midreset_edge");
    @(negedge clk);
    rst_n = 1'b1;
    apply(4'd6, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    accept();
    send(4'd4, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);

    check("drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Bound the run even if the bench itself stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/comparator_4bit.md
Name:
comparator_4bit

Overview:
- Registered magnitude comparator for two WIDTH-bit operands (default 4).
- Raises exactly one of three flags: less-than, greater-than or equal.
- Supports unsigned or two's-complement comparison.
- Cascade inputs let several instances chain into wider comparators.
- Used as a leaf datapath block; one result per accepted input, one-cycle latency.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  A/B/cascade/signed_mode sampled on this clock edge when high.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- signed_mode  input  1  0 = unsigned compare, 1 = two's-complement compare.
- casc_lt  input  1  less-than result from the less-significant stage; tie 0 when standalone.
- casc_gt  input  1  greater-than result from the less-significant stage; tie 0 when standalone.
- casc_eq  input  1  equal result from the less-significant stage; tie 1 when standalone.
- out_valid  output  1  high for exactly one cycle per accepted input.
- A_lt_B  output  1  registered A < B.
- A_gt_B  output  1  registered A > B.
- A_eq_B  output  1  registered A == B.

Behaviour:
- Reset (rst_n low, asynchronous, independent of clk):
  - out_valid, A_lt_B, A_gt_B and A_eq_B all clear to 0 immediately.
  - They stay 0 until the first accepted input after rst_n deasserts.
- Latency:
  - When in_valid is 1 at a rising edge, the result is registered at that edge.
  - out_valid goes to 1 in the following cycle.
  - Fully pipelined: back-to-back in_valid gives back-to-back results.
- When in_valid is 0 at an edge:
  - out_valid goes to 0.
  - The three flags hold their previous values.
- Exactly one flag is 1 whenever out_valid is 1. After the first result the flags stay one-hot.
- Unsigned mode: plain binary magnitude compare of A and B.
- Signed mode:
  - A and B are two's-complement values; the MSB is the sign.
  - Example: A=4'b1000 (-8), B=4'b0111 (+7) gives A_lt_B.
- Cascade applies only when A == B:
  - If A != B, the cascade inputs are ignored and the local result wins.
  - If A == B, priority is casc_eq > casc_gt > casc_lt:
    - casc_eq=1 gives A_eq_B.
    - else casc_gt=1 gives A_gt_B.
    - else casc_lt=1 gives A_lt_B.
    - all cascade inputs 0 gives A_eq_B.
- signed_mode is sampled together with the operands. Changing it between transactions affects only subsequent results.
- Boundary cases:
  - Unsigned: A=0/B=all-ones gives lt; A=all-ones/B=0 gives gt.
  - Signed: the most-negative vs most-positive value gives lt.
- Reset mid-stream: a pending result is discarded and the outputs clear at once. A transaction presented in the same cycle rst_n deasserts is accepted normally at the next edge.
- Implementation: combinational compare from an MSB-first scan or subtract-and-flags, followed by a single register stage. No X outputs after reset.

Test Plan:
- Reset: rst_n low, drive arbitrary inputs -> all outputs 0 immediately and no out_valid. Release, then A=2, B=5, unsigned, in_valid for one cycle -> next cycle out_valid=1, A_lt_B=1, others 0.
- Standalone unsigned, back-to-back: A=8,B=7 then A=12,B=12 (casc_eq=1) -> gt, then eq, on consecutive cycles; out_valid=1 both cycles, then 0 with flags held.
- Signed mode: A=4'b1000, B=4'b0111 -> A_lt_B=1. Same operands with signed_mode=0 -> A_gt_B=1. A=4'b1111, B=4'b0000 in signed mode -> lt.
- Cascade: A=B=9 with casc_eq=0, casc_gt=1 -> A_gt_B. A=B=9 with casc_lt=1 only -> A_lt_B. A=B=9 with all cascade 0 -> A_eq_B. A=3, B=9 with casc_gt=1 -> A_lt_B (cascade ignored).
- Exhaustive: all 256 A/B pairs in each mode with standalone cascade ties -> flags match a reference compare and are one-hot on every out_valid.
- Mid-stream reset: assert rst_n low asynchronously between edges while in_valid is streaming -> outputs clear to 0 before the next edge. Results resume one cycle after the first post-reset accepted input.
